// File: rtl/mult_pkg.sv
// Shared constants, state encoding and sizing helper for the shift-add multiplier.
package mult_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_add_row.sv
// One row of WIDTH ripple-carry full adders; sub inverts y and injects a carry-in of 1.
module mult_add_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] y_eff;

  assign y_eff    = y ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]     = x[i] ^ y_eff[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y_eff[i]) | (carry[i] & (x[i] ^ y_eff[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per enabled cycle, valid/ready on both sides.
// Define MULT_SIGNED_EN to build the two's-complement variant.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned       CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]   LastCnt = CntW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;

  logic [WIDTH-1:0]     pp;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic                 sub;
  logic                 top_bit;
  logic                 last;

  assign last = (cnt_q == LastCnt);
  assign pp   = b_q[0] ? a_q : '0;

`ifdef MULT_SIGNED_EN
  // The multiplier sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted.
  assign sub     = last;
  // Bit WIDTH of the sign-extended sum; becomes the arithmetic-shift fill.
  assign top_bit = acc_q[2*WIDTH-1] ^ pp[WIDTH-1] ^ sub ^ cout;
`else
  assign sub     = 1'b0;
  assign top_bit = cout;
`endif

  mult_add_row #(
    .WIDTH (WIDTH)
  ) u_add_row (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (pp),
    .sub  (sub),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    if (ena) begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          acc_d = {top_bit, sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Reset forces IDLE, so in_ready is also gated by rst_n to stay low while held in reset.
  assign in_ready  = rst_n & (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign product   = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ena4, iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        ena8, iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int compared   = 0;
  int mismatched = 0;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena4),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .out_valid (ov4),
    .out_ready (or4),
    .product   (p4),
    .busy      (busy4)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena8),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .product   (p8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands read as w-bit numbers.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input int w);
    longint sa, sb, p, mask;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
`ifdef MULT_SIGNED_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 transaction: optional ena stall mid-run, optional out_ready backpressure.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                     input int stall_after, input int stall_len, input int hold,
                     input string tag);
    int k;
    k = 0;
    while (!ir4 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, 32'(ir4), 32'd1);
    a4  = a;
    b4  = b;
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    a4  = 4'($urandom);
    b4  = 4'($urandom);
    k = 0;
    while (!ov4 && k < 40) begin
      k++;
      ena4 = !(stall_len > 0 && k > stall_after && k <= stall_after + stall_len);
      tick();
    end
    ena4 = 1'b1;
    check({tag, "_latency"}, 32'(k), 32'(4 + stall_len));
    check({tag, "_product"}, 32'(p4), 32'(exp));
    check({tag, "_busy"}, 32'(busy4), 32'd1);
    check({tag, "_noready"}, 32'(ir4), 32'd0);
    for (int h = 0; h < hold; h++) begin
      iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      check({tag, "_hold_prod"}, 32'(p4), 32'(exp));
      check({tag, "_hold_valid"}, 32'(ov4), 32'd1);
      check({tag, "_hold_ready"}, 32'(ir4), 32'd0);
    end
    or4 = 1'b1;
    iv4 = 1'($urandom);
    tick();
    or4 = 1'b0;
    iv4 = 1'b0;
    check({tag, "_post_valid"}, 32'(ov4), 32'd0);
    check({tag, "_post_busy"}, 32'(busy4), 32'd0);
    check({tag, "_post_prod"}, 32'(p4), 32'd0);
    check({tag, "_post_ready"}, 32'(ir4), 32'd1);
  endtask

  logic [31:0] exp8_q[$];

  initial begin
    int e, prev, got;
    logic [3:0] ra, rb;
    rst_n = 1'b0;
    ena4 = 1'b1; iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    ena8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("rst_in_ready", 32'(ir4), 32'd0);
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_product", 32'(p4), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(ir4), 32'd1);

`ifdef MULT_SIGNED_EN
    op4(4'h8, 4'h8, 8'h40, 0, 0, 0, "s_m8m8");
    op4(4'h8, 4'h7, 8'hC8, 0, 0, 1, "s_m8p7");
    op4(4'h7, 4'hF, 8'hF9, 0, 0, 0, "s_p7m1");
    op4(4'h6, 4'h7, 8'd42, 1, 2, 0, "s_stall");
`else
    op4(4'd15, 4'd15, 8'd225, 0, 0, 0, "max");
    op4(4'd0, 4'd9, 8'd0, 0, 0, 0, "zero");
    op4(4'd15, 4'd15, 8'd225, 0, 0, 3, "bp");
    op4(4'd6, 4'd7, 8'd42, 1, 2, 0, "stall");
`endif

    // ena low in IDLE: the input handshake must not complete
    ena4 = 1'b0; iv4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    tick();
    check("ena_low_idle_busy", 32'(busy4), 32'd0);
    ena4 = 1'b1; iv4 = 1'b0;

    // Reset mid-run aborts the operation
    iv4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    tick();
    iv4 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov4), 32'd0);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_prod", 32'(p4), 32'd0);
    check("midrst_ready", 32'(ir4), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_rel_ready", 32'(ir4), 32'd1);
    op4(4'd3, 4'd5, 8'(ref_mul(16'd3, 16'd5, 4)), 0, 0, 0, "after_rst");

    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      op4(ra, rb, 8'(ref_mul(16'(ra), 16'(rb), 4)), $urandom_range(0, 3),
          $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    // WIDTH=8: max operands, then back-to-back throughput with in_valid/out_ready held high
    a8 = 8'd255; b8 = 8'd255;
`ifdef MULT_SIGNED_EN
    exp8_q.push_back(32'd1);
`else
    exp8_q.push_back(32'd65025);
`endif
    iv8 = 1'b1; or8 = 1'b1;
    e = 0; prev = 0; got = 0;
    while (got < 3 && e < 60) begin
      tick();
      e++;
      if (ov8) begin
        check("w8_product", 32'(p8), exp8_q.pop_front());
        if (got == 0) check("w8_latency", 32'(e), 32'd9);
        else          check("w8_period", 32'(e - prev), 32'd10);
        prev = e;
        got++;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        exp8_q.push_back(ref_mul(16'(a8), 16'(b8), 8));
      end
    end
    iv8 = 1'b0;
    check("w8_results", 32'(got), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
